da1spi: RTL and testbench

Serial transmitter for the PmodDA1 (AD7303) 8-bit DAC. It sits directly downstream of the test-pattern generator on the Nexys3. It accepts an 8-bit command and an 8-bit data byte over a four-phase `dacdav`/`davdac` handshake. It shifts them out MSB-first as one 16-bit frame on `dacsync`/`dacout`/`dacsck`, which map to JA1/JA2/JA4.

---
 rtl/da1_pkg.sv | 31 +++
 rtl/da1spi_if.sv | 21 ++
 rtl/da1_sckdiv.sv | 31 +++
 rtl/da1spi.sv | 152 +++++++++++++++
 tb/tb_da1spi.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/da1_pkg.sv
// da1_pkg: shared constants for the PmodDA1 (AD7303) serial transmitter.
// Build option: define DA1_DUALCH_EN to send channel A then channel B per handshake.
package da1_pkg;

    localparam int FRAME_W  = 16;
    localparam int CMD_AB   = 2;
    localparam int CMD_LDAC = 5;

    localparam logic [7:0] CMD_DEFAULT = 8'd19;

    typedef logic [2:0] da1_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
`ifdef DA1_DUALCH_EN
    localparam logic [2:0] ST_SHIFT2 = 3'd4;
`endif

    // Force the A/B select and LDAC bits: both clear for channel A (held in
    // the input register), both set for channel B (which also updates both outputs).
    function automatic logic [7:0] cmd_chan(input logic [7:0] cmd, input logic second);
        logic [7:0] r;
        r           = cmd;
        r[CMD_AB]   = second;
        r[CMD_LDAC] = second;
        return r;
    endfunction

endpackage

// File: rtl/da1spi_if.sv
// da1spi_if: four-phase handshake between the pattern generator and da1spi.
// Build option: DA1_DUALCH_EN adds the channel-B data byte dacdatb.
interface da1spi_if;

    logic       dacdav;
    logic [7:0] daccmd;
    logic [7:0] dacdata;
`ifdef DA1_DUALCH_EN
    logic [7:0] dacdatb;
`endif
    logic       davdac;

`ifdef DA1_DUALCH_EN
    modport master (output dacdav, daccmd, dacdata, dacdatb, input davdac);
    modport slave  (input dacdav, daccmd, dacdata, dacdatb, output davdac);
`else
    modport master (output dacdav, daccmd, dacdata, input davdac);
    modport slave  (input dacdav, daccmd, dacdata, output davdac);
`endif

endinterface

// File: rtl/da1_sckdiv.sv
// da1_sckdiv: phase timer for dacsck. Emits a one-cycle strobe at the end of
// every CLKDIV-cycle phase while enabled; parked at zero when disabled so each
// frame starts with a full-length first phase.
module da1_sckdiv #(
    parameter int CLKDIV = 1
) (
    input  logic dacclk,
    input  logic dacrstn,
    input  logic en,
    output logic stb
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt;

    assign stb = en && (cnt == LAST);

    // Count cycles within the current dacsck phase; restart on each strobe.
    always_ff @(posedge dacclk or negedge dacrstn) begin
        if (!dacrstn) begin
            cnt <= '0;
        end else if (!en || stb) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/da1spi.sv
// da1spi: AD7303 serial transmitter. Latches {cmd,data} on a dacdav handshake,
// shifts the 16-bit frame MSB-first on dacout/dacsck under dacsync, then
// acknowledges with davdac and enforces a SYNC_GAP idle gap between frames.
// Build option: DA1_DUALCH_EN sends channel A then channel B before the acknowledge.
module da1spi
    import da1_pkg::*;
#(
    parameter int CLKDIV   = 1,
    parameter int SYNC_GAP = 2
) (
    input  logic     dacclk,
    input  logic     dacrstn,
    da1spi_if.slave  bus,
    output logic     dacout,
    output logic     dacsck,
    output logic     dacsync
);

    localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

    da1_state_t         state;
    logic [FRAME_W-1:0] sreg;
    logic [3:0]         bitcnt;
    logic [GW-1:0]      gapcnt;
    logic               davdac_q;
    logic               shifting;
    logic               ph_stb;
`ifdef DA1_DUALCH_EN
    logic               second_q;
    logic [FRAME_W-1:0] f2_q;
`endif

    // dacout is the MSB flop of the shift register, so it only moves when the
    // register shifts, which happens at the start of a low phase.
    assign dacout     = sreg[FRAME_W-1];
    assign bus.davdac = davdac_q;

`ifdef DA1_DUALCH_EN
    assign shifting = (state == ST_SHIFT) || (state == ST_SHIFT2);
`else
    assign shifting = (state == ST_SHIFT);
`endif

    da1_sckdiv #(.CLKDIV(CLKDIV)) u_sckdiv (
        .dacclk  (dacclk),
        .dacrstn (dacrstn),
        .en      (shifting),
        .stb     (ph_stb)
    );

    // Frame sequencer: handshake capture, bit shifting, acknowledge and sync gap.
    always_ff @(posedge dacclk or negedge dacrstn) begin
        if (!dacrstn) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            bitcnt   <= '0;
            gapcnt   <= '0;
            davdac_q <= 1'b0;
            dacsck   <= 1'b1;
            dacsync  <= 1'b1;
`ifdef DA1_DUALCH_EN
            second_q <= 1'b0;
            f2_q     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef DA1_DUALCH_EN
                    if (second_q) begin
                        second_q <= 1'b0;
                        sreg     <= f2_q;
                        bitcnt   <= 4'd15;
                        dacsck   <= 1'b0;
                        dacsync  <= 1'b0;
                        state    <= ST_SHIFT2;
                    end else if (bus.dacdav) begin
                        sreg     <= {cmd_chan(bus.daccmd, 1'b0), bus.dacdata};
                        f2_q     <= {cmd_chan(bus.daccmd, 1'b1), bus.dacdatb};
                        bitcnt   <= 4'd15;
                        dacsck   <= 1'b0;
                        dacsync  <= 1'b0;
                        state    <= ST_SHIFT;
                    end
`else
                    if (bus.dacdav) begin
                        sreg     <= {bus.daccmd, bus.dacdata};
                        bitcnt   <= 4'd15;
                        dacsck   <= 1'b0;
                        dacsync  <= 1'b0;
                        state    <= ST_SHIFT;
                    end
`endif
                end

`ifdef DA1_DUALCH_EN
                ST_SHIFT, ST_SHIFT2: begin
`else
                ST_SHIFT: begin
`endif
                    if (ph_stb) begin
                        if (!dacsck) begin
                            dacsck <= 1'b1;
                        end else begin
                            sreg <= {sreg[FRAME_W-2:0], 1'b0};
                            if (bitcnt == 4'd0) begin
                                dacsync <= 1'b1;
`ifdef DA1_DUALCH_EN
                                if (state == ST_SHIFT) begin
                                    second_q <= 1'b1;
                                    gapcnt   <= '0;
                                    state    <= ST_GAP;
                                end else begin
                                    davdac_q <= 1'b1;
                                    state    <= ST_DONE;
                                end
`else
                                davdac_q <= 1'b1;
                                state    <= ST_DONE;
`endif
                            end else begin
                                bitcnt <= bitcnt - 4'd1;
                                dacsck <= 1'b0;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (!bus.dacdav) begin
                        davdac_q <= 1'b0;
                        gapcnt   <= '0;
                        state    <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gapcnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gapcnt <= gapcnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da1spi.sv
// tb_da1spi: scoreboard bench for da1spi. Two instances (CLKDIV=1 and CLKDIV=3)
// each feed a DAC-side capture model; expected frame words are queued by the
// stimulus and checked by the capture monitor when dacsync closes a frame.
// Honours DA1_DUALCH_EN (dacdatb is always driven as dacdata ^ 8'h80).
module tb_da1spi;

    localparam int SG = 2;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    da1spi_if ifa ();
    da1spi_if ifb ();

    logic out_a, sck_a, sync_a;
    logic out_b, sck_b, sync_b;

    da1spi #(.CLKDIV(1), .SYNC_GAP(SG)) u_a (
        .dacclk  (clk),
        .dacrstn (rstn),
        .bus     (ifa),
        .dacout  (out_a),
        .dacsck  (sck_a),
        .dacsync (sync_a)
    );

    da1spi #(.CLKDIV(3), .SYNC_GAP(SG)) u_b (
        .dacclk  (clk),
        .dacrstn (rstn),
        .bus     (ifb),
        .dacout  (out_b),
        .dacsck  (sck_b),
        .dacsync (sync_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] cap_sh[2];
    int          cap_n[2] = '{0, 0};
    int          hi[2]    = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic sync_of(input int s);
        return (s == 0) ? sync_a : sync_b;
    endfunction
    function automatic logic sck_of(input int s);
        return (s == 0) ? sck_a : sck_b;
    endfunction
    function automatic logic out_of(input int s);
        return (s == 0) ? out_a : out_b;
    endfunction
    function automatic logic davd(input int s);
        return (s == 0) ? ifa.davdac : ifb.davdac;
    endfunction

    function automatic int exp_lat(input int cd);
`ifdef DA1_DUALCH_EN
        return 2 * (1 + 32 * cd) + SG;
`else
        return 1 + 32 * cd;
`endif
    endfunction

    task automatic push(input int s, input logic [15:0] w);
        if (s == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic push_frames(input int s, input logic [7:0] c, input logic [7:0] d);
`ifdef DA1_DUALCH_EN
        push(s, {c & 8'hDB, d});
        push(s, {c | 8'h24, d ^ 8'h80});
`else
        push(s, {c, d});
`endif
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] c, input logic [7:0] d);
        if (s == 0) begin
            ifa.dacdav  = v;
            ifa.daccmd  = c;
            ifa.dacdata = d;
`ifdef DA1_DUALCH_EN
            ifa.dacdatb = d ^ 8'h80;
`endif
        end else begin
            ifb.dacdav  = v;
            ifb.daccmd  = c;
            ifb.dacdata = d;
`ifdef DA1_DUALCH_EN
            ifb.dacdatb = d ^ 8'h80;
`endif
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One four-phase handshake; entered and left 1ns after a rising edge.
    task automatic hs(input int s, input logic [7:0] c, input logic [7:0] d,
                      input bit tchk, input bit chg, input bit stuck);
        int n;
        int cd;
        int budget;
        int lows;
        bit seen;
        cd     = (s == 0) ? 1 : 3;
        budget = exp_lat(cd) + 60;
        drive(s, 1'b1, c, d);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (tchk && n <= 4 * cd) begin
                chk("sync_low", sync_of(s), 1'b0);
                chk("sck_phase", sck_of(s), ((n - 1) / cd) % 2);
                if (n == 1) chk("first_bit", out_of(s), c[7]);
            end
            if (chg && n == 10) drive(s, 1'b1, c, 8'hFF);
            if (davd(s) === 1'b1) seen = 1'b1;
        end
        chk("ack_seen", seen, 1'b1);
        if (tchk) chk("ack_latency", n, exp_lat(cd));
        if (stuck && seen) begin
            lows = 0;
            repeat (100) begin
                @(posedge clk);
                #1;
                if (sync_of(s) !== 1'b1) lows++;
            end
            chk("stuck_no_frame", lows, 0);
            chk("stuck_ack_held", davd(s), 1'b1);
        end
        drive(s, 1'b0, c, d);
        @(posedge clk);
        #1;
        chk("ack_deassert", davd(s), 1'b0);
    endtask

    // DAC-side capture: sample DIN on each rising dacsck inside a frame.
    always @(posedge sck_a) if (sync_a === 1'b0) begin
        cap_sh[0] = {cap_sh[0][14:0], out_a};
        cap_n[0]++;
    end
    always @(posedge sck_b) if (sync_b === 1'b0) begin
        cap_sh[1] = {cap_sh[1][14:0], out_b};
        cap_n[1]++;
    end

    task automatic frame_end(input int s);
        logic [15:0] e;
        int qs;
        qs = (s == 0) ? q0.size() : q1.size();
        if (cap_n[s] == 16) begin
            if (qs == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_unexpected[%0d]: got %h expected none", s, cap_sh[s]);
            end else begin
                if (s == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("frame_word", {16'h0, cap_sh[s]}, {16'h0, e});
            end
        end else if (cap_n[s] != 0 && rstn === 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_length[%0d]: got %0d bits expected 16", s, cap_n[s]);
        end
        cap_n[s] = 0;
    endtask

    always @(posedge sync_a) frame_end(0);
    always @(posedge sync_b) frame_end(1);

    // Count dacsync-high cycles and check the gap whenever a new frame opens.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (sync_of(s) === 1'b1) begin
                hi[s]++;
            end else begin
                if (hi[s] != 0) chk("sync_gap", (hi[s] >= SG), 1);
                hi[s] = 0;
            end
        end
    end

    initial begin
        int w;
        logic [7:0] d;
        rstn = 1'b0;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        cyc(3);
        for (int s = 0; s < 2; s++) begin
            chk("rst_sync", sync_of(s), 1'b1);
            chk("rst_sck", sck_of(s), 1'b1);
            chk("rst_out", out_of(s), 1'b0);
            chk("rst_davdac", davd(s), 1'b0);
        end
        rstn = 1'b1;
        cyc(2);

        // single frame
        push(0, 16'h13A5);
`ifdef DA1_DUALCH_EN
        push(0, 16'h3725);
`endif
        hs(0, 8'h13, 8'hA5, 1'b1, 1'b0, 1'b0);
        cyc(5);

        // data changes mid-shift are ignored
        push(0, 16'h13A5);
`ifdef DA1_DUALCH_EN
        push(0, 16'h3725);
`endif
        hs(0, 8'h13, 8'hA5, 1'b1, 1'b1, 1'b0);
        cyc(5);

        // CLKDIV=3 instance
        push(1, 16'h1301);
`ifdef DA1_DUALCH_EN
        push(1, 16'h3781);
`endif
        hs(1, 8'h13, 8'h01, 1'b1, 1'b0, 1'b0);
        cyc(5);

        // dav held high after the acknowledge
        push(0, 16'h1377);
`ifdef DA1_DUALCH_EN
        push(0, 16'h37F7);
`endif
        hs(0, 8'h13, 8'h77, 1'b1, 1'b0, 1'b1);
        cyc(5);

`ifdef DA1_DUALCH_EN
        push(0, 16'h1340);
        push(0, 16'h37C0);
        hs(0, 8'h13, 8'h40, 1'b1, 1'b0, 1'b0);
        cyc(5);
`endif

        // reset in the middle of a frame
        drive(0, 1'b1, 8'h13, 8'h3C);
        cyc(10);
        rstn = 1'b0;
        #1;
        chk("abort_sync", sync_a, 1'b1);
        chk("abort_sck", sck_a, 1'b1);
        chk("abort_davdac", ifa.davdac, 1'b0);
        drive(0, 1'b0, 8'h13, 8'h3C);
        cyc(3);
        chk("abort_davdac_hold", ifa.davdac, 1'b0);
        rstn = 1'b1;
        cyc(2);
        push(0, 16'h135A);
`ifdef DA1_DUALCH_EN
        push(0, 16'h37DA);
`endif
        hs(0, 8'h13, 8'h5A, 1'b1, 1'b0, 1'b0);

        // counting generator, back to back
        for (int i = 0; i < 256; i++) begin
            d = 8'(i + 1);
            push_frames(0, 8'd19, d);
            hs(0, 8'd19, d, 1'b0, 1'b0, 1'b0);
        end

        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 300) begin
            cyc(1);
            w++;
        end
        chk("queue_a_drained", q0.size(), 0);
        chk("queue_b_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
